fp_add_arbiter: RTL and testbench

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

---
 rtl/fp_add_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_fp_add_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: two request ports share one combinational FP32 adder.
// Each accepted operation is captured, executed in one cycle, then held
// as a response until the owning port accepts it.
// Optional build macro FPADD_ARB_FIXED_PRI_EN: port 0 always wins ties and
// the last-served pointer is removed. Without it, grants are round-robin.

// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
module adder_comb (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y
);

  localparam int unsigned MW = 27;   // 24 mantissa bits + guard, round, sticky

  logic          w_swap;
  logic [31:0]   w_lg;
  logic [31:0]   w_sm;
  logic [7:0]    w_el;
  logic [7:0]    w_es;
  logic [23:0]   w_ml;
  logic [23:0]   w_ms;
  logic [7:0]    w_d;
  logic [4:0]    w_dcl;
  logic [50:0]   w_ext;
  logic [MW-1:0] w_mlx;
  logic [MW-1:0] w_msx;
  logic          w_eff_sub;
  logic [MW:0]   w_sum;
  logic [4:0]    w_lz;
  logic [7:0]    w_sh;
  logic [MW-1:0] w_nm;
  logic [8:0]    w_ne;
  logic          w_rnd;
  logic [31:0]   w_pk;
  logic          w_a_inf;
  logic          w_b_inf;
  logic          w_a_nan;
  logic          w_b_nan;

  // Align, add/subtract, normalise and round; specials override at the end.
  always_comb begin
    w_swap    = (i_b[30:0] > i_a[30:0]);
    w_lg      = w_swap ? i_b : i_a;
    w_sm      = w_swap ? i_a : i_b;
    w_el      = (w_lg[30:23] == 8'd0) ? 8'd1 : w_lg[30:23];
    w_es      = (w_sm[30:23] == 8'd0) ? 8'd1 : w_sm[30:23];
    w_ml      = {(w_lg[30:23] != 8'd0), w_lg[22:0]};
    w_ms      = {(w_sm[30:23] != 8'd0), w_sm[22:0]};
    w_d       = w_el - w_es;
    w_dcl     = (w_d > 8'd27) ? 5'd27 : w_d[4:0];
    w_ext     = {w_ms, 27'd0} >> w_dcl;
    // Everything shifted below the round bit collapses into the sticky bit.
    w_msx     = {w_ext[50:25], w_ext[24] | (|w_ext[23:0])};
    w_mlx     = {w_ml, 3'b000};
    w_eff_sub = w_lg[31] ^ w_sm[31];
    w_sum     = w_eff_sub ? ({1'b0, w_mlx} - {1'b0, w_msx})
                          : ({1'b0, w_mlx} + {1'b0, w_msx});

    w_lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (w_sum[i]) w_lz = 5'(26 - i);
    end

    w_sh = 8'd0;
    if (w_sum[27]) begin
      w_nm = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_ne = {1'b0, w_el} + 9'd1;
    end else begin
      // Stop normalising at the minimum exponent so small results go denormal.
      w_sh = ({3'b000, w_lz} < w_el) ? {3'b000, w_lz} : (w_el - 8'd1);
      w_nm = w_sum[26:0] << w_sh;
      w_ne = w_nm[26] ? ({1'b0, w_el} - {1'b0, w_sh}) : 9'd0;
    end

    // Rounding carry ripples into the exponent field (denormal->normal, etc).
    w_rnd = w_nm[2] & (w_nm[1] | w_nm[0] | w_nm[3]);
    w_pk  = {w_ne, w_nm[25:3]} + 32'(w_rnd);

    if (w_pk[31:23] >= 9'd255) o_y = {w_lg[31], 8'hFF, 23'd0};
    else                       o_y = {w_lg[31], w_pk[30:0]};

    if (w_sum == 28'd0) o_y = {(w_eff_sub ? 1'b0 : w_lg[31]), 31'd0};

    w_a_inf = (i_a[30:23] == 8'hFF) && (i_a[22:0] == 23'd0);
    w_b_inf = (i_b[30:23] == 8'hFF) && (i_b[22:0] == 23'd0);
    w_a_nan = (i_a[30:23] == 8'hFF) && (i_a[22:0] != 23'd0);
    w_b_nan = (i_b[30:23] == 8'hFF) && (i_b[22:0] != 23'd0);
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (i_a[31] != i_b[31]))) begin
      o_y = 32'h7FC00000;
    end else if (w_a_inf) begin
      o_y = i_a;
    end else if (w_b_inf) begin
      o_y = i_b;
    end
  end

endmodule

module fp_add_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [1:0]  req_sub,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy
);

  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [DW-1:0] r_result;
  logic          r_port;
  logic [1:0]    r_rsp_valid;
  logic          r_busy;
  logic          w_grant;
  logic          w_accept;
  logic          w_rsp_done;
  logic [DW-1:0] w_sum;
`ifndef FPADD_ARB_FIXED_PRI_EN
  logic          r_last;
`endif

  // Single shared adder fed from the captured operand registers.
  adder_comb u_add (
    .i_a (r_a),
    .i_b (r_b),
    .o_y (w_sum)
  );

  // Port selection among the currently valid requesters.
  always_comb begin
`ifdef FPADD_ARB_FIXED_PRI_EN
    w_grant = ~req_valid[0];
`else
    w_grant = (req_valid == 2'b11) ? ~r_last : req_valid[1];
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next state, request handshake and response completion.
  always_comb begin
    w_next_state = r_state;
    req_ready    = 2'b00;
    w_accept     = 1'b0;
    w_rsp_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rst_n && (req_valid != 2'b00)) begin
          req_ready    = w_grant ? 2'b10 : 2'b01;
          w_accept     = 1'b1;
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: w_next_state = S_RESP;
      S_RESP: begin
        if (rsp_ready[r_port]) begin
          w_rsp_done   = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand capture, result register and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_port      <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_busy      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_port <= w_grant;
        if (w_grant) begin
          r_a <= req_a1;
          r_b <= req_b1 ^ {req_sub[1], 31'd0};
        end else begin
          r_a <= req_a0;
          r_b <= req_b0 ^ {req_sub[0], 31'd0};
        end
      end
      if (r_state == S_EXEC) r_result <= w_sum;
      r_rsp_valid <= (w_next_state == S_RESP) ? {r_port, ~r_port} : 2'b00;
      r_busy      <= (w_next_state != S_IDLE);
    end
  end

`ifndef FPADD_ARB_FIXED_PRI_EN
  // Last-served pointer; reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_last <= 1'b1;
    else if (w_rsp_done) r_last <= r_port;
  end
`endif

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_result;
  assign busy      = r_busy;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Scoreboard bench for fp_add_arbiter: the driver issues random and directed
// requests; a negedge monitor predicts grants from an arbitration model,
// pushes exact-arithmetic FP32 results and checks each response.
module tb_fp_add_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [1:0]  req_sub = 2'b00;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b11;
  logic [31:0] rsp_data;
  logic        busy;

  typedef struct packed { logic port; logic [31:0] data; } exp_t;

  exp_t        sb_q[$];
  int          grants[$];
  int          n_vec = 0, n_bad = 0, cyc = 0, acc_cyc = 0, n_rsp = 0;
  logic        inflight = 1'b0, seen_rsp = 1'b0, m_last = 1'b1, last_port = 1'b0;
  logic [1:0]  acc_flag = 2'b00, step_acc = 2'b00;
  logic [31:0] last_data = '0;

  fp_add_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_sub(req_sub), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Exact magnitude of an FP32 value in units of 2^-149.
  function automatic logic [279:0] mag_of(input logic [31:0] x);
    int e;
    e = int'(x[30:23]);
    if (e == 0) return 280'(x[22:0]);
    return 280'({1'b1, x[22:0]}) << (e - 1);
  endfunction

  // Reference FP32 add: exact integer sum, then round-to-nearest-even.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [279:0] ma, mb, mag, rem, half, one;
    logic         sr;
    logic [24:0]  q;
    int           p, sh, e;
    ma = mag_of(a);
    mb = mag_of(b);
    if (a[31] == b[31])  begin mag = ma + mb; sr = a[31]; end
    else if (ma >= mb)   begin mag = ma - mb; sr = (ma == mb) ? 1'b0 : a[31]; end
    else                 begin mag = mb - ma; sr = b[31]; end
    if (mag == '0) return {sr, 31'd0};
    p = 0;
    for (int i = 0; i < 280; i++) if (mag[i]) p = i;
    if (p < 24) return {sr, 7'd0, mag[23:0]};
    sh   = p - 23;
    q    = 25'(mag >> sh);
    one  = 280'(1);
    rem  = mag & ((one << sh) - one);
    half = one << (sh - 1);
    if ((rem > half) || ((rem == half) && q[0])) q = q + 25'd1;
    if (q[24]) begin q = q >> 1; sh++; end
    e = sh + 1;
    if (e >= 255) return {sr, 8'hFF, 23'd0};
    return {sr, 8'(e), q[22:0]};
  endfunction

  function automatic logic [1:0] oh(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  // Random finite operands biased toward close exponents, cancellation,
  // denormals, zeros and overflow.
  task automatic gen_ops(output logic [31:0] a, output logic [31:0] b);
    int k, t;
    a = $urandom;
    a[30:23] = 8'($urandom_range(0, 254));
    if ($urandom_range(0, 7) == 0) a[30:23] = 8'd0;
    b = $urandom;
    k = int'($urandom_range(0, 9));
    case (k)
      0: b = a;
      1: b = a ^ 32'h80000000;
      2: b[30:23] = 8'd0;
      3: b = {b[31], 31'd0};
      4: begin a[30:23] = 8'd254; b[30:23] = 8'd254; end
      default: begin
        t = int'(a[30:23]) + int'($urandom_range(0, 60)) - 30;
        if (t < 0) t = 0;
        if (t > 254) t = 254;
        b[30:23] = 8'(t);
      end
    endcase
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] b, input logic s);
    if (p == 0) begin req_a0 = a; req_b0 = b; end
    else        begin req_a1 = a; req_b1 = b; end
    req_sub[p] = s;
  endtask

  task automatic set_rand(input int p);
    logic [31:0] a, b;
    gen_ops(a, b);
    set_port(p, a, b, 1'($urandom_range(0, 1)));
  endtask

  // Advance one cycle; accepted requests are dropped or replaced.
  task automatic step(input bit keep);
    @(posedge clk);
    #1;
    step_acc = acc_flag;
    for (int i = 0; i < 2; i++) begin
      if (acc_flag[i]) begin
        acc_flag[i] = 1'b0;
        if (keep) set_rand(i);
        else      req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_rsp(input int target, input string name);
    for (int k = 0; k < 60 && n_rsp < target; k++) step(1'b0);
    if (n_rsp < target) fail_timeout(name);
  endtask

  // Any drop of reset discards the in-flight operation from the model.
  always @(negedge rst_n) begin
    sb_q.delete();
    inflight = 1'b0;
    m_last   = 1'b1;
    acc_flag = 2'b00;
  end

  // Monitor: grant prediction, response scoreboard, latency.
  always @(negedge clk) begin : mon
    logic       g;
    logic [1:0] exp_rdy;
    exp_t       e;
    cyc++;
    if (rst_n) begin
`ifdef FPADD_ARB_FIXED_PRI_EN
      g = ~req_valid[0];
`else
      g = (req_valid == 2'b11) ? ~m_last : req_valid[1];
`endif
      exp_rdy = (!inflight && (req_valid != 2'b00)) ? oh(g) : 2'b00;
      if ((req_valid != 2'b00) || (req_ready != 2'b00))
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
      if ((req_valid != 2'b00) || inflight)
        check("busy", 32'(busy), 32'(inflight));

      if (inflight && !seen_rsp && (rsp_valid == 2'b00) && (cyc > acc_cyc + 2)) begin
        fail_timeout("rsp_latency");
        inflight = 1'b0;
        if (sb_q.size() > 0) void'(sb_q.pop_front());
      end

      if (rsp_valid != 2'b00) begin
        if (!inflight || (sb_q.size() == 0)) begin
          check("spurious_rsp_valid", 32'(rsp_valid), 32'(0));
        end else begin
          if (!seen_rsp) begin
            check("latency", 32'(cyc - acc_cyc), 32'(2));
            seen_rsp = 1'b1;
          end
          check("rsp_valid", 32'(rsp_valid), 32'(oh(sb_q[0].port)));
          check("rsp_data", rsp_data, sb_q[0].data);
          if (rsp_ready[sb_q[0].port] && rsp_valid[sb_q[0].port]) begin
            e         = sb_q.pop_front();
            last_data = rsp_data;
            last_port = e.port;
            m_last    = e.port;
            inflight  = 1'b0;
            n_rsp++;
          end
        end
      end

      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.port = 1'(i);
          e.data = (i == 0) ? ref_add(req_a0, req_b0 ^ {req_sub[0], 31'd0})
                            : ref_add(req_a1, req_b1 ^ {req_sub[1], 31'd0});
          sb_q.push_back(e);
          grants.push_back(i);
          inflight    = 1'b1;
          seen_rsp    = 1'b0;
          acc_cyc     = cyc;
          acc_flag[i] = 1'b1;
        end
      end
    end
  end

  initial begin
    int base;
    // Reset state, with both ports already requesting.
    set_rand(0);
    set_rand(1);
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;

    // Both ports continuously valid from reset release.
    for (int k = 0; k < 60 && grants.size() < 4; k++) step(1'b1);
    if (grants.size() < 4) fail_timeout("grant_order");
    else begin
      for (int i = 0; i < 4; i++) begin
`ifdef FPADD_ARB_FIXED_PRI_EN
        check("grant_order", 32'(grants[i]), 32'(0));
`else
        check("grant_order", 32'(i % 2), 32'(grants[i]) ^ 32'(0));
`endif
      end
    end
    req_valid = 2'b00;
    for (int k = 0; k < 20 && inflight; k++) step(1'b0);

    // Directed add on port 0 and subtract on port 1.
    set_port(0, 32'h3F800000, 32'h40000000, 1'b0);
    req_valid[0] = 1'b1;
    wait_rsp(n_rsp + 1, "dir_add");
    check("dir_add_data", last_data, 32'h40400000);
    check("dir_add_port", 32'(last_port), 32'(0));
    set_port(1, 32'h40400000, 32'h3F800000, 1'b1);
    req_valid[1] = 1'b1;
    wait_rsp(n_rsp + 1, "dir_sub");
    check("dir_sub_data", last_data, 32'h40000000);
    check("dir_sub_port", 32'(last_port), 32'(1));

    // Response back-pressure; the other port's ready must be ignored.
    rsp_ready = 2'b10;
    set_rand(0);
    req_valid[0] = 1'b1;
    for (int k = 0; k < 20 && rsp_valid == 2'b00; k++) step(1'b0);
    set_rand(1);
    req_valid[1] = 1'b1;
    repeat (5) begin
      step(1'b0);
      check("stall_busy", 32'(busy), 32'(1));
      check("stall_req_ready", 32'(req_ready), 32'(0));
      check("stall_rsp_valid", 32'(rsp_valid), 32'(1));
    end
    base = n_rsp;
    rsp_ready = 2'b01;
    step(1'b0);
    check("stall_done_valid", 32'(rsp_valid), 32'(0));
    check("stall_done_count", 32'(n_rsp), 32'(base + 1));
    rsp_ready = 2'b11;
    wait_rsp(base + 2, "after_stall");

    // Reset during EXEC discards the operation.
    set_rand(0);
    req_valid[0] = 1'b1;
    step_acc = 2'b00;
    for (int k = 0; k < 20 && step_acc == 2'b00; k++) step(1'b0);
    req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    check("rstx_req_ready", 32'(req_ready), 32'(0));
    check("rstx_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rstx_rsp_data", rsp_data, 32'h0);
    check("rstx_busy", 32'(busy), 32'(0));
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    rst_n = 1'b1;
    repeat (5) begin
      step(1'b0);
      check("rstx_no_rsp", 32'(rsp_valid), 32'(0));
    end
    set_rand(1);
    req_valid[1] = 1'b1;
    wait_rsp(n_rsp + 1, "after_reset");

    // Random traffic with random response back-pressure.
    repeat (600) begin
      step(1'b0);
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 2) == 0)) begin
          set_rand(i);
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = 2'($urandom_range(0, 3));
    end
    rsp_ready = 2'b11;
    for (int k = 0; k < 40 && (req_valid != 2'b00 || inflight); k++) step(1'b0);
    check("drain_empty", 32'(sb_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
